// File: rtl/alu_control_mdu.sv
// ALU control for the MIPS EX stage: combinational ALUopt/func decode plus an
// iterative multiply/divide unit with HI/LO registers and an issue-stage stall.
module alu_control_mdu #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [2:0]        ALUopt,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [CTR_W-1:0]  ALUctr,
  output logic              illegal,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              md_done,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned ACC_W = 2 * DATA_W;

  localparam logic [2:0] OPT_ADD = 3'b000;
  localparam logic [2:0] OPT_SUB = 3'b001;
  localparam logic [2:0] OPT_AND = 3'b010;
  localparam logic [2:0] OPT_OR  = 3'b011;
  localparam logic [2:0] OPT_R   = 3'b100;
  localparam logic [2:0] OPT_SLT = 3'b101;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  localparam logic [CTR_W-1:0] C_AND  = CTR_W'(4'b0000);
  localparam logic [CTR_W-1:0] C_OR   = CTR_W'(4'b0001);
  localparam logic [CTR_W-1:0] C_ADD  = CTR_W'(4'b0010);
  localparam logic [CTR_W-1:0] C_XOR  = CTR_W'(4'b0011);
  localparam logic [CTR_W-1:0] C_SLL  = CTR_W'(4'b0100);
  localparam logic [CTR_W-1:0] C_SRL  = CTR_W'(4'b0101);
  localparam logic [CTR_W-1:0] C_SUB  = CTR_W'(4'b0110);
  localparam logic [CTR_W-1:0] C_SLT  = CTR_W'(4'b0111);
  localparam logic [CTR_W-1:0] C_SLTU = CTR_W'(4'b1000);
  localparam logic [CTR_W-1:0] C_MFHI = CTR_W'(4'b1001);
  localparam logic [CTR_W-1:0] C_MFLO = CTR_W'(4'b1010);
  localparam logic [CTR_W-1:0] C_NOR  = CTR_W'(4'b1100);
  localparam logic [CTR_W-1:0] C_NOP  = CTR_W'(4'b1111);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_opa;
  logic               r_dvz;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [DATA_W-1:0]  r_hi;
  logic [DATA_W-1:0]  r_lo;
  logic               r_md_done;

  logic               w_is_mdu;
  logic               w_uses_hilo;
  logic               w_accept;
  logic               w_signed;
  logic               w_last;
  logic [DATA_W-1:0]  w_abs_a;
  logic [DATA_W-1:0]  w_abs_b;
  logic [DATA_W:0]    w_sum;
  logic [ACC_W-1:0]   w_mul_next;
  logic [ACC_W-1:0]   w_mul_res;
  logic [DATA_W:0]    w_shift;
  logic [DATA_W+1:0]  w_diff;
  logic [ACC_W-1:0]   w_div_next;
  logic [DATA_W-1:0]  w_quo;
  logic [DATA_W-1:0]  w_rem;

  // ALUopt / func decode
  always_comb begin
    ALUctr  = C_ADD;
    illegal = 1'b0;
    case (ALUopt)
      OPT_ADD: ALUctr = C_ADD;
      OPT_SUB: ALUctr = C_SUB;
      OPT_AND: ALUctr = C_AND;
      OPT_OR:  ALUctr = C_OR;
      OPT_SLT: ALUctr = C_SLT;
      OPT_R: begin
        case (func)
          F_ADD:  ALUctr = C_ADD;
          F_SUB:  ALUctr = C_SUB;
          F_AND:  ALUctr = C_AND;
          F_OR:   ALUctr = C_OR;
          F_SLT:  ALUctr = C_SLT;
          F_NOR:  ALUctr = C_NOR;
          F_XOR:  ALUctr = C_XOR;
          F_SLL:  ALUctr = C_SLL;
          F_SRL:  ALUctr = C_SRL;
          F_SLTU: ALUctr = C_SLTU;
          F_MFHI: ALUctr = C_MFHI;
          F_MFLO: ALUctr = C_MFLO;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: ALUctr = C_NOP;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  // mult/multu/div/divu share func[5:2]; func[1] selects divide, func[0] unsigned
  assign w_is_mdu    = (func[5:2] == 4'b0110);
  assign w_uses_hilo = w_is_mdu | (func == F_MFHI) | (func == F_MFLO);
  assign w_accept    = valid_in & (ALUopt == OPT_R) & w_is_mdu;
  assign w_signed    = ~func[0];

  assign busy  = (r_state != S_IDLE);
  assign stall = busy & valid_in & (ALUopt == OPT_R) & w_uses_hilo;

  assign hi      = r_hi;
  assign lo      = r_lo;
  assign md_done = r_md_done;

  assign w_abs_a = (w_signed & op_a[DATA_W-1]) ? -op_a : op_a;
  assign w_abs_b = (w_signed & op_b[DATA_W-1]) ? -op_b : op_b;
  assign w_last  = (r_cnt == CNT_W'(1));

  // Shift-add multiply: upper half accumulates, lower half holds the multiplier
  assign w_sum      = {1'b0, r_acc[ACC_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_sum, r_acc[DATA_W-1:1]};
  assign w_mul_res  = r_neg_q ? -w_mul_next : w_mul_next;

  // Restoring divide: upper half is the partial remainder, lower half shifts
  // the dividend out and the quotient in
  assign w_shift    = {r_acc[ACC_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_b};
  assign w_div_next = w_diff[DATA_W+1]
                    ? {w_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                    : {w_diff[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b1};
  assign w_quo = r_neg_q ? -w_div_next[DATA_W-1:0] : w_div_next[DATA_W-1:0];
  assign w_rem = r_neg_r ? -w_div_next[ACC_W-1:DATA_W] : w_div_next[ACC_W-1:DATA_W];

  // MDU sequencer and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_opa     <= '0;
      r_dvz     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_md_done <= 1'b0;
    end else begin
      r_md_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= func[1] ? S_DIV : S_MUL;
            r_cnt   <= CNT_W'(DATA_W);
            r_acc   <= {DATA_W'(0), w_abs_a};
            r_b     <= w_abs_b;
            r_opa   <= op_a;
            r_dvz   <= (op_b == '0);
            r_neg_q <= w_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            r_neg_r <= w_signed & op_a[DATA_W-1];
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_hi      <= w_mul_res[ACC_W-1:DATA_W];
            r_lo      <= w_mul_res[DATA_W-1:0];
            r_md_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            // divide by zero returns all-ones quotient and the raw dividend
            r_hi      <= r_dvz ? r_opa : w_rem;
            r_lo      <= r_dvz ? '1    : w_quo;
            r_md_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: decode table, MDU vectors through a result
// scoreboard, hazard/stall sequences, reset abort and an 8-bit build.
module tb_alu_control_mdu;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [2:0]  ALUopt;
  logic [5:0]  func;
  logic [31:0] op_a, op_b;
  logic [3:0]  ALUctr;
  logic        illegal, stall, md_done, busy;
  logic [31:0] hi, lo;

  logic        rst8, v8;
  logic [2:0]  opt8;
  logic [5:0]  func8;
  logic [7:0]  a8, b8;
  logic [3:0]  ctr8;
  logic        ill8, st8, done8, busy8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbq[$];
  logic [63:0] sb_e;

  alu_control_mdu #(.DATA_W(32), .CTR_W(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ALUopt(ALUopt), .func(func),
    .op_a(op_a), .op_b(op_b), .ALUctr(ALUctr), .illegal(illegal), .stall(stall),
    .hi(hi), .lo(lo), .md_done(md_done), .busy(busy)
  );

  alu_control_mdu #(.DATA_W(8), .CTR_W(4)) dut8 (
    .clk(clk), .rst(rst8), .valid_in(v8), .ALUopt(opt8), .func(func8),
    .op_a(a8), .op_b(b8), .ALUctr(ctr8), .illegal(ill8), .stall(st8),
    .hi(hi8), .lo(lo8), .md_done(done8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model for the 32-bit MDU, returns {hi, lo}
  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (fn)
      F_MULT:  r = 64'(sa * sb);
      F_MULTU: r = {32'b0, a} * {32'b0, b};
      F_DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      F_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Scoreboard: compare HI/LO against the oldest expectation on each md_done
  always @(posedge clk) begin
    #2;
    if (md_done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: md_done with empty queue hi=%0h lo=%0h", hi, lo);
      end else begin
        sb_e = sbq.pop_front();
        chk("sb_hi", 64'(hi), 64'(sb_e[63:32]));
        chk("sb_lo", 64'(lo), 64'(sb_e[31:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (md_done) begin
        lat = c;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    chk("done_pulse", 64'(md_done), 64'(0));
  endtask

  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    valid_in = 1'b1; ALUopt = 3'b100; func = fn; op_a = a; op_b = b;
    sbq.push_back(exp);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  typedef struct {
    logic [2:0] opt;
    logic [5:0] fn;
    logic [3:0] ctr;
    logic       ill;
  } dec_vec_t;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } mdu_vec_t;

  dec_vec_t dv[$];
  mdu_vec_t mv[$];
  logic [5:0] fns[4];

  initial begin
    dv.push_back('{3'b000, 6'b101010, 4'b0010, 1'b0});
    dv.push_back('{3'b001, 6'b000000, 4'b0110, 1'b0});
    dv.push_back('{3'b010, 6'b100000, 4'b0000, 1'b0});
    dv.push_back('{3'b011, 6'b111111, 4'b0001, 1'b0});
    dv.push_back('{3'b101, 6'b100010, 4'b0111, 1'b0});
    dv.push_back('{3'b110, 6'b100000, 4'b0010, 1'b1});
    dv.push_back('{3'b111, 6'b100000, 4'b0010, 1'b1});
    dv.push_back('{3'b100, 6'b100000, 4'b0010, 1'b0});
    dv.push_back('{3'b100, 6'b100010, 4'b0110, 1'b0});
    dv.push_back('{3'b100, 6'b100101, 4'b0001, 1'b0});
    dv.push_back('{3'b100, 6'b100100, 4'b0000, 1'b0});
    dv.push_back('{3'b100, 6'b101010, 4'b0111, 1'b0});
    dv.push_back('{3'b100, 6'b100111, 4'b1100, 1'b0});
    dv.push_back('{3'b100, 6'b100110, 4'b0011, 1'b0});
    dv.push_back('{3'b100, 6'b000000, 4'b0100, 1'b0});
    dv.push_back('{3'b100, 6'b000010, 4'b0101, 1'b0});
    dv.push_back('{3'b100, 6'b101011, 4'b1000, 1'b0});
    dv.push_back('{3'b100, 6'b010000, 4'b1001, 1'b0});
    dv.push_back('{3'b100, 6'b010010, 4'b1010, 1'b0});
    dv.push_back('{3'b100, 6'b011000, 4'b1111, 1'b0});
    dv.push_back('{3'b100, 6'b011001, 4'b1111, 1'b0});
    dv.push_back('{3'b100, 6'b011010, 4'b1111, 1'b0});
    dv.push_back('{3'b100, 6'b011011, 4'b1111, 1'b0});
    dv.push_back('{3'b100, 6'b111111, 4'b0010, 1'b1});
    dv.push_back('{3'b100, 6'b000001, 4'b0010, 1'b1});

    mv.push_back('{F_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA});
    mv.push_back('{F_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA});
    mv.push_back('{F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD});
    mv.push_back('{F_DIVU,  32'd100,       32'd7,        32'd2,         32'd14});
    mv.push_back('{F_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF});
    mv.push_back('{F_DIVU,  32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF});
    mv.push_back('{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000});
    mv.push_back('{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0});
    mv.push_back('{F_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9});
    mv.push_back('{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD});

    fns[0] = F_MULT; fns[1] = F_MULTU; fns[2] = F_DIV; fns[3] = F_DIVU;

    rst = 1'b1; valid_in = 1'b0; ALUopt = 3'b000; func = 6'b0; op_a = '0; op_b = '0;
    rst8 = 1'b1; v8 = 1'b0; opt8 = 3'b000; func8 = 6'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst8 = 1'b0;

    // Reset state
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_done", 64'(md_done), 64'(0));
    valid_in = 1'b1; ALUopt = 3'b100; func = F_MFLO;
    #1;
    chk("idle_mflo_stall", 64'(stall), 64'(0));
    valid_in = 1'b0;

    // Decode table
    foreach (dv[i]) begin
      ALUopt = dv[i].opt; func = dv[i].fn;
      #1;
      chk($sformatf("dec_ctr[%0d]", i), 64'(ALUctr), 64'(dv[i].ctr));
      chk($sformatf("dec_ill[%0d]", i), 64'(illegal), 64'(dv[i].ill));
    end
    @(posedge clk); #1;

    // Directed MDU vectors
    foreach (mv[i]) begin
      issue(mv[i].fn, mv[i].a, mv[i].b, {mv[i].ehi, mv[i].elo});
      chk("busy_after_accept", 64'(busy), 64'(1));
      wait_done(32);
    end

    // Random MDU vectors against the model
    for (int i = 0; i < 8; i++) begin
      logic [5:0] fn;
      logic [31:0] a, b;
      fn = fns[$urandom_range(0, 3)];
      a  = $urandom();
      b  = $urandom() >> $urandom_range(0, 31);
      issue(fn, a, b, model(fn, a, b));
      wait_done(32);
    end

    // mflo right behind a mult stalls until the product is in LO
    begin
      int n;
      issue(F_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
      valid_in = 1'b1; func = F_MFLO;
      n = 0;
      for (int c = 0; c < 40; c++) begin
        if (!stall) break;
        n++;
        @(posedge clk); #1;
      end
      chk("mflo_stall_cycles", 64'(n), 64'(32));
      chk("mflo_busy_low", 64'(busy), 64'(0));
      chk("mflo_lo", 64'(lo), 64'(32'hFFFF_FFFA));
      valid_in = 1'b0;
      @(posedge clk); #1;
    end

    // Non-MDU op never stalls; a held MDU op is accepted once stall drops
    begin
      issue(F_MULT, 32'd7, 32'hFFFF_FFFF, {32'hFFFF_FFFF, 32'hFFFF_FFF9});
      valid_in = 1'b1; ALUopt = 3'b100; func = 6'b100000;
      #1;
      chk("add_no_stall", 64'(stall), 64'(0));
      chk("add_busy", 64'(busy), 64'(1));
      func = F_DIVU; op_a = 32'd100; op_b = 32'd7;
      sbq.push_back({32'd2, 32'd14});
      #1;
      chk("mdu_held_stall", 64'(stall), 64'(1));
      for (int c = 0; c < 40; c++) begin
        if (!stall) break;
        @(posedge clk); #1;
      end
      chk("held_stall_drop", 64'(stall), 64'(0));
      @(posedge clk); #1;
      valid_in = 1'b0;
      wait_done(32);
    end

    // Reset in the middle of a divide
    valid_in = 1'b1; ALUopt = 3'b100; func = F_DIV; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    chk("abort_done", 64'(md_done), 64'(0));
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_done(32);

    // Reset wins over a same-cycle accept
    rst = 1'b1; valid_in = 1'b1; ALUopt = 3'b100; func = F_MULT; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    chk("rst_prio_busy", 64'(busy), 64'(0));

    // 8-bit build: most-negative / -1
    begin
      int lat8;
      v8 = 1'b1; opt8 = 3'b100; func8 = F_DIV; a8 = 8'h80; b8 = 8'hFF;
      #1;
      chk("w8_ctr", 64'(ctr8), 64'(4'b1111));
      chk("w8_ill", 64'(ill8), 64'(0));
      chk("w8_stall", 64'(st8), 64'(0));
      @(posedge clk); #1;
      v8 = 1'b0;
      chk("w8_busy", 64'(busy8), 64'(1));
      lat8 = 0;
      for (int c = 1; c <= 30; c++) begin
        @(posedge clk); #1;
        if (done8) begin
          lat8 = c;
          break;
        end
      end
      chk("w8_latency", 64'(lat8), 64'(8));
      chk("w8_lo", 64'(lo8), 64'(8'h80));
      chk("w8_hi", 64'(hi8), 64'(8'h00));
    end

    repeat (40) @(posedge clk);
    #3;
    chk("sb_drain", 64'(sbq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
